// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: register map offsets, CLAIM word layout and default sizing
// shared by the interrupt controller, its priority encoder and its bus interface.
package int_ctrl_pkg;
    localparam int N_SRC_DEF = 6;
    localparam int ID_W_DEF  = 3;

    localparam logic [1:0] OFS_MASK  = 2'd0;
    localparam logic [1:0] OFS_EDGE  = 2'd1;
    localparam logic [1:0] OFS_PEND  = 2'd2;
    localparam logic [1:0] OFS_CLAIM = 2'd3;

    localparam int CLAIM_VLD = 31;
endpackage

// File: rtl/int_ctrl_if.sv
// int_ctrl_if: bridge-side register bus of the interrupt controller.
// The bridge is the master; the controller is the slave.
interface int_ctrl_if;
    logic [29:0] addr;
    logic        sel;
    logic        we;
    logic        rd_en;
    logic [31:0] din;
    logic [31:0] dout;

    modport master (output addr, sel, we, rd_en, din, input dout);
    modport slave  (input addr, sel, we, rd_en, din, output dout);
endinterface

// File: rtl/int_prio_enc.sv
// int_prio_enc: combinational lowest-index-first priority encoder.
// Reports whether any request is set and the id of the lowest set index.
module int_prio_enc
    import int_ctrl_pkg::*;
#(
    parameter int N    = N_SRC_DEF,
    parameter int ID_W = ID_W_DEF
) (
    input  logic [N-1:0]    req,
    output logic            valid,
    output logic [ID_W-1:0] id
);

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        valid = 1'b0;
        id    = {ID_W{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            id = req[i] ? ID_W'(i) : id;
        end
        valid = |req;
    end

endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: programmable interrupt controller (mask, edge/level, pending, claim/EOI).
// Define INT_CTRL_NESTING_EN to let higher-priority sources preempt an in-service one.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEF,
    parameter int ID_W  = ID_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src,
    int_ctrl_if.slave        bus,
    output logic             irq
);

    localparam logic [ID_W:0] N_SRC_ID = (ID_W + 1)'(N_SRC);

    logic [N_SRC-1:0] mask_r, edge_cfg_r, pend_r, insvc_r, src_q_r;
    logic             irq_r;
    logic [N_SRC-1:0] mask_n_s, edge_cfg_n_s, pend_n_s, insvc_n_s;
    logic [N_SRC-1:0] allow_s, allow_n_s, elig_s, elig_n_s;
    logic [N_SRC-1:0] rise_s, w1c_s, claim_oh_s, eoi_oh_s, edge_chg_s, din_s;
    logic [1:0]       ofs_s;
    logic             wr_s, rd_s, claim_vld_s, claim_s, eoi_ok_s;
    logic [ID_W-1:0]  claim_id_s, eoi_id_s;
    logic [31:0]      claim_word_s;
    logic             unused_bus_s;

    // addr carries byte-address bits [31:2], so the register offset is its low two bits.
    assign ofs_s        = bus.addr[1:0];
    assign din_s        = bus.din[N_SRC-1:0];
    assign eoi_id_s     = bus.din[ID_W-1:0];
    assign unused_bus_s = ^{bus.addr[29:2], bus.din[31:N_SRC]};

    assign wr_s     = bus.sel & bus.we;
    assign rd_s     = bus.sel & bus.rd_en & ~bus.we;
    assign claim_s  = rd_s & (ofs_s == OFS_CLAIM) & claim_vld_s;
    assign eoi_ok_s = wr_s & (ofs_s == OFS_CLAIM) & ({1'b0, eoi_id_s} < N_SRC_ID);

    assign rise_s     = src & ~src_q_r;
    assign w1c_s      = (wr_s && ofs_s == OFS_PEND) ? din_s : {N_SRC{1'b0}};
    assign edge_chg_s = (wr_s && ofs_s == OFS_EDGE) ? (din_s ^ edge_cfg_r) : {N_SRC{1'b0}};
    assign claim_oh_s = claim_s ? (N_SRC'(1'b1) << claim_id_s) : {N_SRC{1'b0}};
    assign eoi_oh_s   = eoi_ok_s ? (N_SRC'(1'b1) << eoi_id_s) : {N_SRC{1'b0}};

`ifdef INT_CTRL_NESTING_EN
    logic            floor_vld_s, floor_n_vld_s;
    logic [ID_W-1:0] floor_id_s, floor_n_id_s;

    int_prio_enc #(.N(N_SRC), .ID_W(ID_W)) u_floor (
        .req(insvc_r), .valid(floor_vld_s), .id(floor_id_s)
    );
    int_prio_enc #(.N(N_SRC), .ID_W(ID_W)) u_floor_n (
        .req(insvc_n_s), .valid(floor_n_vld_s), .id(floor_n_id_s)
    );

    assign allow_s   = floor_vld_s ? ((N_SRC'(1'b1) << floor_id_s) - N_SRC'(1'b1))
                                   : {N_SRC{1'b1}};
    assign allow_n_s = floor_n_vld_s ? ((N_SRC'(1'b1) << floor_n_id_s) - N_SRC'(1'b1))
                                     : {N_SRC{1'b1}};
`else
    assign allow_s   = (|insvc_r)   ? {N_SRC{1'b0}} : {N_SRC{1'b1}};
    assign allow_n_s = (|insvc_n_s) ? {N_SRC{1'b0}} : {N_SRC{1'b1}};
`endif

    assign elig_s   = pend_r & mask_r & ~insvc_r & allow_s;
    assign elig_n_s = pend_n_s & mask_n_s & ~insvc_n_s & allow_n_s;

    int_prio_enc #(.N(N_SRC), .ID_W(ID_W)) u_claim (
        .req(elig_s), .valid(claim_vld_s), .id(claim_id_s)
    );

    assign claim_word_s = claim_vld_s ? ((32'h1 << CLAIM_VLD) | 32'(claim_id_s)) : 32'h0;

    // Read mux; upper bits of the narrow registers read as zero.
    always_comb begin
        bus.dout = 32'h0;
        if (bus.sel && bus.rd_en) begin
            case (ofs_s)
                OFS_MASK:  bus.dout = {{(32 - N_SRC){1'b0}}, mask_r};
                OFS_EDGE:  bus.dout = {{(32 - N_SRC){1'b0}}, edge_cfg_r};
                OFS_PEND:  bus.dout = {{(32 - N_SRC){1'b0}}, pend_r};
                OFS_CLAIM: bus.dout = claim_word_s;
                default:   bus.dout = 32'h0;
            endcase
        end else begin
            bus.dout = 32'h0;
        end
    end

    // Next-state: a fresh edge wins over W1C/claim clears; an EDGE change drops the pending bit.
    always_comb begin
        mask_n_s     = mask_r;
        edge_cfg_n_s = edge_cfg_r;
        if (wr_s && ofs_s == OFS_MASK) begin
            mask_n_s = din_s;
        end else begin
            mask_n_s = mask_r;
        end
        if (wr_s && ofs_s == OFS_EDGE) begin
            edge_cfg_n_s = din_s;
        end else begin
            edge_cfg_n_s = edge_cfg_r;
        end
        pend_n_s  = ~edge_chg_s & ((edge_cfg_r & (rise_s | (pend_r & ~(w1c_s | claim_oh_s))))
                                   | (~edge_cfg_r & src));
        insvc_n_s = (insvc_r | claim_oh_s) & ~eoi_oh_s;
    end

    // State registers; irq tracks the eligibility of the state being loaded.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_r     <= {N_SRC{1'b0}};
            edge_cfg_r <= {N_SRC{1'b0}};
            pend_r     <= {N_SRC{1'b0}};
            insvc_r    <= {N_SRC{1'b0}};
            src_q_r    <= {N_SRC{1'b0}};
            irq_r      <= 1'b0;
        end else begin
            mask_r     <= mask_n_s;
            edge_cfg_r <= edge_cfg_n_s;
            pend_r     <= pend_n_s;
            insvc_r    <= insvc_n_s;
            src_q_r    <= src;
            irq_r      <= |elig_n_s;
        end
    end

    assign irq = irq_r;

endmodule
